// File: rtl/command_scheduler_if.sv
// Bundle of requester, PSL command and PSL response signals for command_scheduler.
// master = scheduler side, slave = environment (requesters + PSL).
interface command_scheduler_if;
  logic        enable;
  logic [0:7]  ha_croom;

  logic        req0_valid;
  logic        req1_valid;
  logic [0:12] req0_com;
  logic [0:12] req1_com;
  logic [0:63] req0_ea;
  logic [0:63] req1_ea;
  logic        req0_ack;
  logic        req1_ack;

  logic        ah_cvalid;
  logic [0:7]  ah_ctag;
  logic        ah_ctagpar;
  logic [0:12] ah_com;
  logic        ah_compar;
  logic [0:63] ah_cea;
  logic        ah_ceapar;
  logic [0:2]  ah_cabt;
  logic [0:15] ah_cch;
  logic [0:11] ah_csize;

  logic        ha_rvalid;
  logic [0:7]  ha_rtag;
  logic        ha_rtagpar;
  logic [0:7]  ha_response;

  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [0:7]  rsp0_code;
  logic [0:7]  rsp1_code;

  logic [0:7]  credits;
  logic        tag_perr;

  modport master (
    input  enable, ha_croom,
    input  req0_valid, req1_valid, req0_com, req1_com, req0_ea, req1_ea,
    output req0_ack, req1_ack,
    output ah_cvalid, ah_ctag, ah_ctagpar, ah_com, ah_compar, ah_cea, ah_ceapar,
    output ah_cabt, ah_cch, ah_csize,
    input  ha_rvalid, ha_rtag, ha_rtagpar, ha_response,
    output rsp0_valid, rsp1_valid, rsp0_code, rsp1_code,
    output credits, tag_perr
  );

  modport slave (
    output enable, ha_croom,
    output req0_valid, req1_valid, req0_com, req1_com, req0_ea, req1_ea,
    input  req0_ack, req1_ack,
    input  ah_cvalid, ah_ctag, ah_ctagpar, ah_com, ah_compar, ah_cea, ah_ceapar,
    input  ah_cabt, ah_cch, ah_csize,
    output ha_rvalid, ha_rtag, ha_rtagpar, ha_response,
    input  rsp0_valid, rsp1_valid, rsp0_code, rsp1_code,
    input  credits, tag_perr
  );
endinterface

// File: rtl/command_scheduler.sv
// Two-requester round-robin PSL command scheduler with credit tracking and response routing.
// Ack is combinational in the grant cycle; ah_cvalid follows one cycle later; responses route one cycle later.
module command_scheduler #(
  parameter int unsigned CSIZE = 128,
  parameter int unsigned CCH   = 0
) (
  input logic                 clock,
  input logic                 reset,
  command_scheduler_if.master bus
);

  localparam logic [0:11] CSIZE_V = CSIZE[11:0];
  localparam logic [0:15] CCH_V   = CCH[15:0];

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        elig0;
  logic        elig1;
  logic        grant0;
  logic        grant1;
  logic        grant_any;
  logic        last_grant;

  logic [7:0]  cred;
  logic [6:0]  seq0;
  logic [6:0]  seq1;

  logic        cvalid_q;
  logic [0:7]  tag_q;
  logic [0:12] com_q;
  logic [0:63] ea_q;

  logic        rtag_ok;
  logic        rsp0_q;
  logic        rsp1_q;
  logic [0:7]  code0_q;
  logic [0:7]  code1_q;
  logic        perr_q;

  assign elig0     = bus.req0_valid && (cred != 8'd0);
  assign elig1     = bus.req1_valid && (cred != 8'd0);
  assign grant_any = grant0 | grant1;
  assign rtag_ok   = ((^bus.ha_rtag) == bus.ha_rtagpar);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // last_grant=1 means requester 0 wins the next tie
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (!bus.enable) begin
          state_nxt = IDLE;
        end else begin
          grant0 = elig0 && (!elig1 || last_grant);
          grant1 = elig1 && (!elig0 || !last_grant);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      seq0       <= 7'd0;
      seq1       <= 7'd0;
      cvalid_q   <= 1'b0;
      tag_q      <= 8'd0;
      com_q      <= 13'd0;
      ea_q       <= 64'd0;
    end else begin
      cvalid_q <= grant_any;
      if (grant_any) begin
        last_grant <= grant1;
        tag_q      <= {grant1, (grant1 ? seq1 : seq0)};
        com_q      <= grant1 ? bus.req1_com : bus.req0_com;
        ea_q       <= grant1 ? bus.req1_ea : bus.req0_ea;
      end
      if (grant0) seq0 <= seq0 + 7'd1;
      if (grant1) seq1 <= seq1 + 7'd1;
    end
  end

  // Grant is only possible with cred>0, so the decrement cannot underflow
  always_ff @(posedge clock) begin
    if (reset) begin
      cred <= 8'd0;
    end else if (state == LOAD) begin
      cred <= bus.ha_croom;
    end else if (grant_any && !bus.ha_rvalid) begin
      cred <= cred - 8'd1;
    end else if (!grant_any && bus.ha_rvalid && (cred != 8'hFF)) begin
      cred <= cred + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      code0_q <= 8'd0;
      code1_q <= 8'd0;
      perr_q  <= 1'b0;
    end else begin
      rsp0_q <= bus.ha_rvalid && rtag_ok && !bus.ha_rtag[0];
      rsp1_q <= bus.ha_rvalid && rtag_ok && bus.ha_rtag[0];
      if (bus.ha_rvalid && rtag_ok && !bus.ha_rtag[0]) code0_q <= bus.ha_response;
      if (bus.ha_rvalid && rtag_ok && bus.ha_rtag[0])  code1_q <= bus.ha_response;
      if (bus.ha_rvalid && !rtag_ok) perr_q <= 1'b1;
    end
  end

  assign bus.req0_ack   = grant0 && !reset;
  assign bus.req1_ack   = grant1 && !reset;

  assign bus.ah_cvalid  = cvalid_q;
  assign bus.ah_ctag    = tag_q;
  assign bus.ah_com     = com_q;
  assign bus.ah_cea     = ea_q;
  assign bus.ah_ctagpar = ^tag_q;
  assign bus.ah_compar  = ^com_q;
  assign bus.ah_ceapar  = ^ea_q;
  assign bus.ah_cabt    = 3'b000;
  assign bus.ah_cch     = CCH_V;
  assign bus.ah_csize   = CSIZE_V;

  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp0_code  = code0_q;
  assign bus.rsp1_code  = code1_q;

  assign bus.credits    = cred;
  assign bus.tag_perr   = perr_q;

endmodule

// File: tb/tb_command_scheduler.sv
// Directed self-checking bench for command_scheduler: reset, issue, arbitration, credits, responses, wrap.
module tb_command_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  command_scheduler_if bus();

  command_scheduler #(.CSIZE(128), .CCH(0)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.req0_valid = 1'b1;
    rst = 1'b1;
    step(); step();
    #1;
    checks++; if (bus.req0_ack !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", bus.req0_ack); end
    checks++; if (bus.ah_cvalid !== 1'b0) begin failures++; $display("FAIL reset_cvalid got=%b exp=0", bus.ah_cvalid); end
    checks++; if (bus.credits !== 8'd0) begin failures++; $display("FAIL reset_credits got=%0d exp=0", bus.credits); end
    checks++; if (bus.tag_perr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", bus.tag_perr); end
    checks++; if (bus.ah_ctag !== 8'h00) begin failures++; $display("FAIL reset_ctag got=%h exp=00", bus.ah_ctag); end
    checks++; if (bus.ah_com !== 13'h0) begin failures++; $display("FAIL reset_com got=%h exp=0", bus.ah_com); end
    checks++; if (bus.ah_cea !== 64'h0) begin failures++; $display("FAIL reset_cea got=%h exp=0", bus.ah_cea); end
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.ah_csize !== 12'd128) begin failures++; $display("FAIL const_csize got=%0d exp=128", bus.ah_csize); end
    checks++; if (bus.ah_cch !== 16'd0) begin failures++; $display("FAIL const_cch got=%0d exp=0", bus.ah_cch); end
    checks++; if (bus.ah_cabt !== 3'b000) begin failures++; $display("FAIL const_cabt got=%b exp=000", bus.ah_cabt); end
    bus.req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_issue();
    do_reset();
    bus.enable = 1'b1; bus.ha_croom = 8'd4;
    bus.req0_valid = 1'b1; bus.req0_com = 13'h0A00; bus.req0_ea = 64'h1000;
    #1;
    checks++; if (bus.req0_ack !== 1'b0) begin failures++; $display("FAIL idle_ack got=%b exp=0", bus.req0_ack); end
    step();
    checks++; if (bus.req0_ack !== 1'b0) begin failures++; $display("FAIL load_ack got=%b exp=0", bus.req0_ack); end
    step();
    checks++; if (bus.credits !== 8'd4) begin failures++; $display("FAIL load_credits got=%0d exp=4", bus.credits); end
    #1;
    checks++; if (bus.req0_ack !== 1'b1) begin failures++; $display("FAIL run_ack0 got=%b exp=1", bus.req0_ack); end
    step();
    bus.req0_valid = 1'b0;
    checks++; if (bus.ah_cvalid !== 1'b1) begin failures++; $display("FAIL issue_cvalid got=%b exp=1", bus.ah_cvalid); end
    checks++; if (bus.ah_ctag !== 8'h00) begin failures++; $display("FAIL issue_ctag got=%h exp=00", bus.ah_ctag); end
    checks++; if (bus.ah_com !== 13'h0A00) begin failures++; $display("FAIL issue_com got=%h exp=0a00", bus.ah_com); end
    checks++; if (bus.ah_cea !== 64'h1000) begin failures++; $display("FAIL issue_cea got=%h exp=1000", bus.ah_cea); end
    checks++; if (bus.ah_compar !== 1'b0) begin failures++; $display("FAIL issue_compar got=%b exp=0", bus.ah_compar); end
    checks++; if (bus.ah_ceapar !== 1'b1) begin failures++; $display("FAIL issue_ceapar got=%b exp=1", bus.ah_ceapar); end
    checks++; if (bus.ah_ctagpar !== 1'b0) begin failures++; $display("FAIL issue_ctagpar got=%b exp=0", bus.ah_ctagpar); end
    checks++; if (bus.credits !== 8'd3) begin failures++; $display("FAIL issue_credits got=%0d exp=3", bus.credits); end
    step();
    checks++; if (bus.ah_cvalid !== 1'b0) begin failures++; $display("FAIL hold_cvalid got=%b exp=0", bus.ah_cvalid); end
    checks++; if (bus.ah_com !== 13'h0A00) begin failures++; $display("FAIL hold_com got=%h exp=0a00", bus.ah_com); end
  endtask

  task automatic test_round_robin();
    logic [7:0]  exp_tag;
    logic [12:0] exp_com;
    do_reset();
    bus.enable = 1'b1; bus.ha_croom = 8'd8;
    bus.req0_valid = 1'b1; bus.req0_com = 13'h0001; bus.req0_ea = 64'h10;
    bus.req1_valid = 1'b1; bus.req1_com = 13'h0003; bus.req1_ea = 64'h20;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (bus.req0_ack !== ((i % 2) == 0)) begin failures++; $display("FAIL rr_ack0 grant=%0d got=%b", i, bus.req0_ack); end
      checks++; if (bus.req1_ack !== ((i % 2) == 1)) begin failures++; $display("FAIL rr_ack1 grant=%0d got=%b", i, bus.req1_ack); end
      step();
      exp_tag = 8'((i % 2) * 128 + i / 2);
      exp_com = ((i % 2) == 0) ? 13'h0001 : 13'h0003;
      checks++; if (bus.ah_ctag !== exp_tag) begin failures++; $display("FAIL rr_tag grant=%0d got=%h exp=%h", i, bus.ah_ctag, exp_tag); end
      checks++; if (bus.ah_com !== exp_com) begin failures++; $display("FAIL rr_com grant=%0d got=%h exp=%h", i, bus.ah_com, exp_com); end
    end
    checks++; if (bus.credits !== 8'd0) begin failures++; $display("FAIL rr_credits got=%0d exp=0", bus.credits); end
    #1;
    checks++; if ({bus.req0_ack, bus.req1_ack} !== 2'b00) begin failures++; $display("FAIL rr_noack got=%b%b exp=00", bus.req0_ack, bus.req1_ack); end
  endtask

  // continues from round robin: credits exhausted, requester 0 still pending
  task automatic test_response_return();
    bus.req1_valid = 1'b0;
    bus.ha_rvalid = 1'b1; bus.ha_rtag = 8'h80; bus.ha_rtagpar = 1'b1; bus.ha_response = 8'h00;
    step();
    bus.ha_rvalid = 1'b0;
    checks++; if (bus.rsp1_valid !== 1'b1) begin failures++; $display("FAIL rsp1_valid got=%b exp=1", bus.rsp1_valid); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL rsp0_quiet got=%b exp=0", bus.rsp0_valid); end
    checks++; if (bus.credits !== 8'd1) begin failures++; $display("FAIL ret_credits got=%0d exp=1", bus.credits); end
    #1;
    checks++; if (bus.req0_ack !== 1'b1) begin failures++; $display("FAIL ret_ack0 got=%b exp=1", bus.req0_ack); end
    step();
    bus.req0_valid = 1'b0;
    checks++; if (bus.ah_ctag !== 8'h04) begin failures++; $display("FAIL ret_tag got=%h exp=04", bus.ah_ctag); end
    checks++; if (bus.credits !== 8'd0) begin failures++; $display("FAIL ret_credits0 got=%0d exp=0", bus.credits); end
    checks++; if (bus.rsp1_valid !== 1'b0) begin failures++; $display("FAIL rsp1_pulse got=%b exp=0", bus.rsp1_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.enable = 1'b1; bus.ha_croom = 8'd2;
    step(); step();
    bus.req0_valid = 1'b1; bus.req0_com = 13'h0005;
    bus.ha_rvalid = 1'b1; bus.ha_rtag = 8'h00; bus.ha_rtagpar = 1'b0; bus.ha_response = 8'h55;
    #1;
    checks++; if (bus.req0_ack !== 1'b1) begin failures++; $display("FAIL same_ack got=%b exp=1", bus.req0_ack); end
    step();
    bus.req0_valid = 1'b0; bus.ha_rvalid = 1'b0;
    checks++; if (bus.credits !== 8'd2) begin failures++; $display("FAIL same_credits got=%0d exp=2", bus.credits); end
    checks++; if (bus.rsp0_valid !== 1'b1) begin failures++; $display("FAIL same_rsp0 got=%b exp=1", bus.rsp0_valid); end
    checks++; if (bus.rsp0_code !== 8'h55) begin failures++; $display("FAIL same_code got=%h exp=55", bus.rsp0_code); end
    checks++; if (bus.ah_cvalid !== 1'b1) begin failures++; $display("FAIL same_cvalid got=%b exp=1", bus.ah_cvalid); end
  endtask

  // continues from back-to-back with credits=2
  task automatic test_tag_parity();
    bus.ha_rvalid = 1'b1; bus.ha_rtag = 8'h01; bus.ha_rtagpar = 1'b0; bus.ha_response = 8'h33;
    step();
    bus.ha_rvalid = 1'b0;
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL perr_rsp got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid); end
    checks++; if (bus.tag_perr !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", bus.tag_perr); end
    checks++; if (bus.credits !== 8'd3) begin failures++; $display("FAIL perr_credits got=%0d exp=3", bus.credits); end
    bus.ha_rvalid = 1'b1; bus.ha_rtag = 8'h00; bus.ha_rtagpar = 1'b0;
    step();
    bus.ha_rvalid = 1'b0;
    checks++; if (bus.tag_perr !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", bus.tag_perr); end
    checks++; if (bus.credits !== 8'd4) begin failures++; $display("FAIL perr_credits2 got=%0d exp=4", bus.credits); end
    checks++; if (bus.rsp0_valid !== 1'b1) begin failures++; $display("FAIL perr_goodrsp got=%b exp=1", bus.rsp0_valid); end
    do_reset();
    checks++; if (bus.tag_perr !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", bus.tag_perr); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.enable = 1'b1; bus.ha_croom = 8'd254;
    step(); step();
    checks++; if (bus.credits !== 8'd254) begin failures++; $display("FAIL sat_load got=%0d exp=254", bus.credits); end
    bus.ha_rvalid = 1'b1; bus.ha_rtag = 8'h00; bus.ha_rtagpar = 1'b0;
    step();
    checks++; if (bus.credits !== 8'd255) begin failures++; $display("FAIL sat_inc got=%0d exp=255", bus.credits); end
    step();
    bus.ha_rvalid = 1'b0;
    checks++; if (bus.credits !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", bus.credits); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.enable = 1'b1; bus.ha_croom = 8'd200;
    bus.req0_valid = 1'b1; bus.req0_com = 13'h0007;
    step(); step();
    for (int n = 1; n <= 129; n++) begin
      step();
      if (n == 1 || n == 127 || n == 128 || n == 129) begin
        checks++;
        if (bus.ah_ctag !== 8'((n - 1) % 128)) begin
          failures++; $display("FAIL wrap_tag grant=%0d got=%h exp=%h", n, bus.ah_ctag, 8'((n - 1) % 128));
        end
      end
    end
    checks++; if (bus.credits !== 8'd71) begin failures++; $display("FAIL wrap_credits got=%0d exp=71", bus.credits); end
    rst = 1'b1;
    #1;
    checks++; if (bus.req0_ack !== 1'b0) begin failures++; $display("FAIL rst_ackgate got=%b exp=0", bus.req0_ack); end
    step();
    checks++; if (bus.ah_cvalid !== 1'b0) begin failures++; $display("FAIL rst_cvalid got=%b exp=0", bus.ah_cvalid); end
    checks++; if (bus.credits !== 8'd0) begin failures++; $display("FAIL rst_credits got=%0d exp=0", bus.credits); end
    rst = 1'b0; bus.req0_valid = 1'b0; bus.ha_croom = 8'd3;
    step(); step();
    checks++; if (bus.credits !== 8'd3) begin failures++; $display("FAIL reload_credits got=%0d exp=3", bus.credits); end
    bus.enable = 1'b0; bus.req0_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ack !== 1'b0) begin failures++; $display("FAIL disable_ack got=%b exp=0", bus.req0_ack); end
    bus.req0_valid = 1'b0;
  endtask

  initial begin
    bus.enable = 1'b0; bus.ha_croom = 8'd0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_com = 13'h0; bus.req1_com = 13'h0;
    bus.req0_ea = 64'h0; bus.req1_ea = 64'h0;
    bus.ha_rvalid = 1'b0; bus.ha_rtag = 8'h0; bus.ha_rtagpar = 1'b0; bus.ha_response = 8'h0;
    test_reset();
    test_single_issue();
    test_round_robin();
    test_response_return();
    test_back_to_back();
    test_tag_parity();
    test_saturate();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
